// File: rtl/main_mem_arbiter.sv
// Two-requester arbiter in front of a single main-memory port.
// One transaction in flight at a time. When both requesters are active,
// the one that was not served last wins. A WAIT-state watchdog aborts a
// transaction that gets no memory response and reports it through o_m_err.
module main_mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_m0_addr,
    input  logic [31:0]  i_m0_wdata,
    input  logic         i_m0_read_req,
    input  logic         i_m0_write_req,
    input  logic [31:0]  i_m1_addr,
    input  logic [31:0]  i_m1_wdata,
    input  logic         i_m1_read_req,
    input  logic         i_m1_write_req,
    output logic         o_m0_ready,
    output logic         o_m1_ready,
    output logic [511:0] o_m_rdata,
    output logic         o_m_err,
    output logic [31:0]  o_mem_addr,
    output logic [31:0]  o_mem_wdata,
    output logic         o_mem_read_req,
    output logic         o_mem_write_req,
    input  logic [511:0] i_mem_rdata,
    input  logic         i_mem_ready
);

    // Counter only needs to reach TIMEOUT-1; the abort happens on that edge.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;       // 0: m0, 1: m1
    logic             r_write;       // latched operation of the granted request
    logic             r_last_grant;  // owner of the most recently completed transaction
    logic [CNT_W-1:0] r_cnt;

    logic        w_m0_act;
    logic        w_m1_act;
    logic        w_any_act;
    logic        w_grant_m1;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_write;

    assign w_m0_act  = i_m0_read_req | i_m0_write_req;
    assign w_m1_act  = i_m1_read_req | i_m1_write_req;
    assign w_any_act = w_m0_act | w_m1_act;

    // Grant decision: on a tie the requester not served last wins; write beats read.
    always_comb begin
        w_grant_m1  = 1'b0;
        w_sel_addr  = i_m0_addr;
        w_sel_wdata = i_m0_wdata;
        w_sel_write = i_m0_write_req;
        if (w_m0_act && w_m1_act) begin
            w_grant_m1 = ~r_last_grant;
        end else if (w_m1_act) begin
            w_grant_m1 = 1'b1;
        end else begin
            w_grant_m1 = 1'b0;
        end
        if (w_grant_m1) begin
            w_sel_addr  = i_m1_addr;
            w_sel_wdata = i_m1_wdata;
            w_sel_write = i_m1_write_req;
        end else begin
            w_sel_addr  = i_m0_addr;
            w_sel_wdata = i_m0_wdata;
            w_sel_write = i_m0_write_req;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_owner         <= 1'b0;
            r_write         <= 1'b0;
            r_last_grant    <= 1'b1;
            r_cnt           <= '0;
            o_m0_ready      <= 1'b0;
            o_m1_ready      <= 1'b0;
            o_m_err         <= 1'b0;
            o_m_rdata       <= '0;
            o_mem_addr      <= 32'h0000_0000;
            o_mem_wdata     <= 32'h0000_0000;
            o_mem_read_req  <= 1'b0;
            o_mem_write_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_m0_ready <= 1'b0;
                    o_m1_ready <= 1'b0;
                    o_m_err    <= 1'b0;
                    if (w_any_act) begin
                        r_owner         <= w_grant_m1;
                        r_write         <= w_sel_write;
                        r_cnt           <= '0;
                        o_mem_addr      <= w_sel_addr;
                        o_mem_wdata     <= w_sel_wdata;
                        o_mem_read_req  <= ~w_sel_write;
                        o_mem_write_req <= w_sel_write;
                        r_state         <= ST_WAIT;
                    end else begin
                        o_mem_read_req  <= 1'b0;
                        o_mem_write_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    o_mem_read_req  <= 1'b0;
                    o_mem_write_req <= 1'b0;
                    // A memory response on the final count still counts as success.
                    if (i_mem_ready) begin
                        if (!r_write) begin
                            o_m_rdata <= i_mem_rdata;
                        end else begin
                            o_m_rdata <= o_m_rdata;
                        end
                        o_m0_ready <= ~r_owner;
                        o_m1_ready <= r_owner;
                        o_m_err    <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        o_m0_ready <= ~r_owner;
                        o_m1_ready <= r_owner;
                        o_m_err    <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    o_m0_ready      <= 1'b0;
                    o_m1_ready      <= 1'b0;
                    o_m_err         <= 1'b0;
                    o_mem_read_req  <= 1'b0;
                    o_mem_write_req <= 1'b0;
                    r_last_grant    <= r_owner;
                    r_cnt           <= '0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    o_m0_ready      <= 1'b0;
                    o_m1_ready      <= 1'b0;
                    o_m_err         <= 1'b0;
                    o_mem_read_req  <= 1'b0;
                    o_mem_write_req <= 1'b0;
                    r_cnt           <= '0;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: requests are pushed to a scoreboard
// when raised and checked, in order, as the arbiter issues and completes them.
module tb_main_mem_arbiter;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic         m0_rd, m0_wr, m1_rd, m1_wr;
    logic         m0_ready, m1_ready, m_err;
    logic [511:0] m_rdata;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_rd, mem_wr;
    logic [511:0] mem_rdata;
    logic         mem_ready;

    typedef struct {
        logic         owner;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           delay;
        logic [511:0] block;
        logic         tmo;
    } txn_t;

    txn_t         sb_q[$];
    logic [511:0] model_rdata;
    int           n_checks = 0;
    int           n_errors = 0;
    int           cnt0;
    int           cnt1;
    logic         seen;

    main_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_read_req(m0_rd), .i_m0_write_req(m0_wr),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_read_req(m1_rd), .i_m1_write_req(m1_wr),
        .o_m0_ready(m0_ready), .o_m1_ready(m1_ready),
        .o_m_rdata(m_rdata), .o_m_err(m_err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_read_req(mem_rd), .o_mem_write_req(mem_wr),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy0"}, m0_ready, 1'b0);
        chk({tag, "_rdy1"}, m1_ready, 1'b0);
        chk({tag, "_err"}, m_err, 1'b0);
        chk({tag, "_memreq"}, {mem_rd, mem_wr}, 2'b00);
        chk({tag, "_addr"}, mem_addr, 32'h0000_0000);
        chk({tag, "_wdata"}, mem_wdata, 32'h0000_0000);
        chk({tag, "_rdata"}, m_rdata, 512'h0);
    endtask

    task automatic raise(input logic owner, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [511:0] block, input logic tmo);
        txn_t t;
        t.owner = owner; t.wr = wr; t.addr = addr; t.wdata = wdata;
        t.delay = delay; t.block = block; t.tmo = tmo;
        sb_q.push_back(t);
        if (owner) begin
            m1_addr = addr; m1_wdata = wdata; m1_rd = rd; m1_wr = wr;
        end else begin
            m0_addr = addr; m0_wdata = wdata; m0_rd = rd; m0_wr = wr;
        end
    endtask

    // Waits for the next issue, plays the memory side, checks the completion.
    task automatic serve();
        txn_t t;
        bit   found;
        int   nw;
        chk("sb_nonempty", 1'(sb_q.size() != 0), 1'b1);
        if (sb_q.size() == 0) return;
        t = sb_q.pop_front();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (mem_rd || mem_wr) found = 1'b1;
        end
        chk("issue_seen", found, 1'b1);
        if (!found) return;
        chk("issue_rd", mem_rd, !t.wr);
        chk("issue_wr", mem_wr, t.wr);
        chk("issue_addr", mem_addr, t.addr);
        if (t.wr) chk("issue_wdata", mem_wdata, t.wdata);
        chk("issue_nordy", {m0_ready, m1_ready}, 2'b00);
        // Requester inputs wiggle during WAIT; the latched values must hold.
        if (t.owner) begin m1_addr = ~t.addr; m1_wdata = ~t.wdata; end
        else         begin m0_addr = ~t.addr; m0_wdata = ~t.wdata; end
        nw = t.tmo ? TMO - 1 : t.delay;
        for (int k = 0; k < nw; k++) begin
            mem_rdata = {16{$urandom()}};
            tick();
            chk("wait_req_low", {mem_rd, mem_wr}, 2'b00);
            chk("wait_addr", mem_addr, t.addr);
            if (t.wr) chk("wait_wdata", mem_wdata, t.wdata);
            chk("wait_nordy", {m0_ready, m1_ready}, 2'b00);
        end
        if (!t.tmo) begin
            mem_ready = 1'b1;
            mem_rdata = t.block;
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = {16{$urandom()}};
        if (!t.tmo && !t.wr) model_rdata = t.block;
        chk("done_rdy0", m0_ready, !t.owner);
        chk("done_rdy1", m1_ready, t.owner);
        chk("done_err", m_err, t.tmo);
        chk("done_rdata", m_rdata, model_rdata);
        chk("done_addr", mem_addr, t.addr);
        if (t.owner) begin m1_rd = 1'b0; m1_wr = 1'b0; end
        else         begin m0_rd = 1'b0; m0_wr = 1'b0; end
        tick();
        chk("post_rdy", {m0_ready, m1_ready, m_err}, 3'b000);
        chk("post_req", {mem_rd, mem_wr}, 2'b00);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        m0_addr = 32'h0; m0_wdata = 32'h0; m0_rd = 1'b0; m0_wr = 1'b0;
        m1_addr = 32'h0; m1_wdata = 32'h0; m1_rd = 1'b0; m1_wr = 1'b0;
        mem_rdata = 512'h0; mem_ready = 1'b0;
        model_rdata = 512'h0;
        #2;
        chk_reset_vals("rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_req", {mem_rd, mem_wr}, 2'b00);

        // Single m0 read, memory answers after 4 cycles.
        raise(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4, {64{8'hAA}}, 1'b0);
        serve();

        // m1 write with read also high: handled as a write, m_rdata untouched.
        raise(1'b1, 1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2, {64{8'h5C}}, 1'b0);
        serve();

        // Reset, then simultaneous reads: m0 first, then m1.
        rst = 1'b1; tick(); rst = 1'b0; model_rdata = 512'h0;
        raise(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, {16{32'h0101_0101}}, 1'b0);
        raise(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3, {16{32'h0202_0202}}, 1'b0);
        serve();
        serve();

        // Continuous requests from both: grants alternate m0, m1, ...
        cnt0 = 1; cnt1 = 1;
        raise(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 0, {16{32'hA000_0000}}, 1'b0);
        raise(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h1234_0000, 1, {16{32'hB000_0000}}, 1'b0);
        for (int k = 0; k < 8; k++) begin
            serve();
            if ((k % 2) == 0 && cnt0 < 4) begin
                raise(1'b0, 1'b1, 1'b0, 32'h0000_2000 + 32'(cnt0 * 4), 32'h0, cnt0 % 3,
                      {16{32'hA000_0000 + 32'(cnt0)}}, 1'b0);
                cnt0++;
            end else if ((k % 2) == 1 && cnt1 < 4) begin
                raise(1'b1, 1'b0, 1'b1, 32'h0000_3000 + 32'(cnt1 * 4), 32'h1234_0000 + 32'(cnt1),
                      cnt1 % 3, {16{32'hB000_0000 + 32'(cnt1)}}, 1'b0);
                cnt1++;
            end
        end

        // No memory response: abort after TMO WAIT cycles with m_err.
        raise(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, {64{8'h77}}, 1'b1);
        serve();

        // Stray mem_ready while idle is ignored.
        mem_ready = 1'b1; mem_rdata = {64{8'hEE}};
        tick();
        mem_ready = 1'b0;
        chk("stray_rdy", {m0_ready, m1_ready, m_err}, 3'b000);
        chk("stray_req", {mem_rd, mem_wr}, 2'b00);
        chk("stray_rdata", m_rdata, model_rdata);
        tick();
        chk("stray_req2", {mem_rd, mem_wr}, 2'b00);

        // Reset two cycles into WAIT, then a late mem_ready.
        m0_addr = 32'h0000_0080; m0_rd = 1'b1;
        tick();
        chk("abort_issue", mem_rd, 1'b1);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk_reset_vals("abort_rst");
        m0_rd = 1'b0;
        tick();
        rst = 1'b0;
        model_rdata = 512'h0;
        mem_ready = 1'b1; mem_rdata = {64{8'h99}};
        tick();
        mem_ready = 1'b0;
        chk("late_rdy", {m0_ready, m1_ready, m_err}, 3'b000);
        chk("late_req", {mem_rd, mem_wr}, 2'b00);
        chk("late_rdata", m_rdata, 512'h0);

        // Normal service afterwards.
        raise(1'b1, 1'b1, 1'b0, 32'h0000_0C00, 32'h0, 2, {16{32'hC0DE_0001}}, 1'b0);
        serve();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: WAIT-state cycles before abort.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 m0_addr / m1_addr  in  32  requester byte address.
REQ-005 m0_wdata / m1_wdata  in  32  requester write word.
REQ-006 m0_read_req / m1_read_req  in  1  level read request, held until own ready.
REQ-007 m0_write_req / m1_write_req  in  1  level write request, held until own ready.
REQ-008 m0_ready / m1_ready  out  1  one-cycle completion pulse.
REQ-009 m_rdata  out  512  captured read block, shared by both requesters.
REQ-010 m_err  out  1  one-cycle pulse with ready when transaction timed out.
REQ-011 mem_addr  out  32  latched address to main memory.
REQ-012 mem_wdata  out  32  latched write word to main memory.
REQ-013 mem_read_req / mem_write_req  out  1  one-cycle issue pulse.
REQ-014 mem_rdata  in  512  main memory read block.
REQ-015 mem_ready  in  1  main memory completion pulse.

Function
REQ-016 States: IDLE, WAIT, RESP; all outputs registered.
REQ-017 IDLE, no request: stay, all pulses low.
REQ-018 IDLE, any request at edge E: grant per REQ-020, latch addr/wdata/op/owner, set mem_*_req=1 for cycle after E, -> WAIT.
REQ-019 Read and write both high from one requester: treat as write.
REQ-020 Both requesters active: grant the one not granted last (last_grant bit); single requester always granted.
REQ-021 WAIT: mem_*_req=0 after first cycle; mem_addr/mem_wdata stable until exit.
REQ-022 WAIT, mem_ready=1: capture mem_rdata into m_rdata (reads only; writes leave m_rdata unchanged), -> RESP.
REQ-023 WAIT counter counts cycles in WAIT; counter reaching TIMEOUT without mem_ready: -> RESP with err flag set, m_rdata unchanged.
REQ-024 RESP: owner's mX_ready=1 for exactly one cycle, m_err=err flag, last_grant<=owner, -> IDLE.
REQ-025 Non-owner's ready never asserts; non-owner request stays pending, served next.
REQ-026 Requesters drop request in the cycle their ready is high; arbiter re-samples only in IDLE.
REQ-027 Minimum latency: request sampled edge E -> mem req cycle E+1 -> ready edge M -> mX_ready in cycle after M.
REQ-028 mem_ready outside WAIT ignored; no state change.
REQ-029 Request changes during WAIT/RESP ignored; latched values used.
REQ-030 Throughput: back-to-back grants alternate when both continuously request.

Reset
REQ-031 rst=1 asynchronously: state=IDLE, last_grant=1 (m0 wins first tie), counter=0, err=0.
REQ-032 During reset: mem_read_req=mem_write_req=0, m0_ready=m1_ready=m_err=0, mem_addr=mem_wdata=0, m_rdata=0.
REQ-033 Reset mid-WAIT abandons transaction; no ready issued; late mem_ready after release ignored.

Verification
REQ-034 m0 read 0x0000_0040, mem returns block 0x...AA after 4 cycles -> one mem_read_req pulse with addr 0x40; m0_ready pulse; m_rdata=block; m1_ready stays 0.
REQ-035 m0 and m1 read simultaneously after reset -> m0 served first, then m1; exactly two mem_read_req pulses, addresses in that order.
REQ-036 Both continuously request 4 transactions each -> grants alternate m0,m1,m0,m1...; no starvation.
REQ-037 m1 write 0x0000_1004 data 0xDEADBEEF -> mem_write_req pulse, mem_addr=0x1004, mem_wdata=0xDEADBEEF stable through WAIT; m1_ready pulse; m_rdata unchanged.
REQ-038 mem_ready never asserted, TIMEOUT=8 -> after 8 WAIT cycles owner ready and m_err pulse together, back to IDLE.
REQ-039 rst asserted 2 cycles into WAIT, mem_ready arrives after release -> no ready pulse, outputs at reset values, next request serviced normally.
